// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared definitions for the bit-serial adder controller.
//   - state_e      : controller state encoding (idle / shift / done)
//   - DefaultWidth : default operand and sum width
package serial_add_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/bit_full_adder.sv
// bit_full_adder: single combinational full-adder cell.
// Ports:
//   i_a, i_b, i_c : addend bits and carry-in
//   o_s, o_co     : sum bit and carry-out
module bit_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_c;
  assign o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequencing controller for a bit-serial adder.
// Captures two WIDTH-bit operands on start, runs one full-adder cell for WIDTH
// cycles LSB first with a registered carry, then pulses done for one cycle.
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   start        : request, sampled only while idle
//   a, b, sub    : operands and subtract select, captured on the accepting edge
//   busy         : high while shifting
//   done         : one-cycle pulse when sum/carry are valid
//   sum, carry   : result register and final carry-out
// Build option: define SERIAL_ADD_CTRL_SUB_EN to enable subtraction via sub
// (carry=1 then means no borrow). Undefined, sub is ignored.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("serial_add_ctrl: WIDTH must be in 2..32");
  end

  state_e          r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum;
  logic [CntW-1:0]  r_cnt;
  logic             r_cy;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;

  logic w_s;
  logic w_co;
  logic w_b_bit;
  logic w_cy_init;

`ifdef SERIAL_ADD_CTRL_SUB_EN
  logic r_sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub <= 1'b0;
    end else if (r_state == StIdle && start) begin
      r_sub <= sub;
    end
  end

  // Two's-complement subtract: invert b into the adder, carry-in of 1.
  assign w_b_bit   = r_b_sr[0] ^ r_sub;
  assign w_cy_init = sub;
`else
  logic w_unused_sub;
  assign w_unused_sub = sub;
  assign w_b_bit      = r_b_sr[0];
  assign w_cy_init    = 1'b0;
`endif

  bit_full_adder u_fa (
    .i_a  (r_a_sr[0]),
    .i_b  (w_b_bit),
    .i_c  (r_cy),
    .o_s  (w_s),
    .o_co (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_cy    <= 1'b0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_cnt   <= '0;
            r_cy    <= w_cy_init;
            r_busy  <= 1'b1;
            r_state <= StShift;
          end
        end
        StShift: begin
          // Sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
          r_sum  <= {w_s, r_sum[WIDTH-1:1]};
          r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_cy   <= w_co;
          r_cnt  <= r_cnt + CntOne;
          if (r_cnt == LastCnt) begin
            r_carry <= w_co;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign carry = r_carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  // Reference: {carry, sum} from plain arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic s);
    int unsigned r;
`ifdef SERIAL_ADD_CTRL_SUB_EN
    if (s) begin
      r = (int'(x) - int'(y)) & ((1 << W) - 1);
      return {(x >= y), W'(r)};
    end
`endif
    r = int'(x) + int'(y);
    return (W + 1)'(r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run one operation; optionally re-pulse start mid-shift with other operands.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                        input bit repulse, input string tag);
    logic [W:0]   exp;
    logic [W-1:0] got_sum;
    logic         got_cy;
    int busy_cnt, done_cnt, done_cyc;
    exp = model(ta, tb, ts);
    @(negedge clk);
    a = ta; b = tb; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_cyc = 0; got_sum = '0; got_cy = 1'b0;
    for (int k = 1; k <= W + 3; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = k;
        got_sum  = sum;
        got_cy   = carry;
      end
      if (repulse && k == 2) begin
        a = 4'b0001; b = 4'b0001; start = 1'b1;
      end else if (repulse && k == 3) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, ".done_cycle"}, done_cyc, W + 1);
    check({tag, ".done_count"}, done_cnt, 1);
    check({tag, ".busy_cycles"}, busy_cnt, W);
    check({tag, ".sum"}, got_sum, exp[W-1:0]);
    check({tag, ".carry"}, got_cy, exp[W]);
    check({tag, ".sum_hold"}, sum, exp[W-1:0]);
    check({tag, ".carry_hold"}, carry, exp[W]);
  endtask

  initial begin
    logic [W:0] exp;
    int prev_done, n_done;
    logic prev_d;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    #1;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.sum", sum, 0);
    check("reset.carry", carry, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(4'b0101, 4'b0011, 1'b0, 1'b0, "add_5_3");
    run_op(4'b1111, 4'b0001, 1'b0, 1'b0, "add_f_1");
    run_op(4'b1111, 4'b1111, 1'b0, 1'b0, "add_f_f");
    run_op(4'b0101, 4'b0011, 1'b0, 1'b1, "repulse");

    // Abort mid-operation with an asynchronous reset.
    @(negedge clk);
    a = 4'b1111; b = 4'b1111; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.sum", sum, 0);
    check("abort.carry", carry, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'b1010, 4'b0110, 1'b0, 1'b0, "after_abort");

    // Start held high: back-to-back operations.
    exp = model(4'b0110, 4'b0111, 1'b0);
    @(negedge clk);
    a = 4'b0110; b = 4'b0111; sub = 1'b0; start = 1'b1;
    prev_done = 0; n_done = 0; prev_d = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (n_done == 1) check("held.first_done", k, W + 1);
        else check("held.spacing", k - prev_done, W + 2);
        check("held.sum", sum, exp[W-1:0]);
        check("held.carry", carry, exp[W]);
        check("held.single_pulse", prev_d, 0);
        prev_done = k;
      end
      prev_d = done;
    end
    check("held.done_count", n_done, 3);
    start = 1'b0;
    repeat (W + 4) @(negedge clk);

    // sub=1: subtracts only when the feature is built in.
    run_op(4'b0101, 4'b0011, 1'b1, 1'b0, "sub_5_3");
    run_op(4'b0011, 4'b0101, 1'b1, 1'b0, "sub_3_5");

    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
             1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
